add_sum_stage: RTL

Registered final stage of the ADD unit's parallel-prefix adder. It sits directly downstream of the last prefix level and consumes its 32 group generate/propagate pairs, the per-bit propagate vector and carry-in. From these it forms the sum, carry-out and condition flags, and presents them to the VLIW writeback path over a valid/ready handshake. A two-entry skid buffer lets the upstream prefix levels keep issuing while writeback stalls.

---
 rtl/add_pkg.sv | 27 ++
 rtl/add_sum_stage_if.sv | 31 +++
 rtl/add_skid_buf.sv | 72 +++++++
 rtl/add_sum_stage.sv | 55 +++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and constants for the ADD unit's final prefix-adder stage.
// Holds the operand/tag widths, the prefix pair bit positions, the result entry and the buffer count encoding.
package add_pkg;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    // Position of the generate / propagate bit within each 2-bit prefix pair
    localparam int G_BIT = 1;
    localparam int P_BIT = 0;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } result_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

endpackage

// File: rtl/add_sum_stage_if.sv
// Bus between the last prefix level, the sum stage and the writeback path.
// The slave modport is the sum stage; the master modport is the upstream/writeback side that drives it.
interface add_sum_stage_if;
    import add_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   prefix;
    logic [WIDTH-1:0]     prop;
    logic                 cin;
    logic [TAG_W-1:0]     tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
    logic                 neg;
    logic [TAG_W-1:0]     tag_out;

    modport slave (
        input  in_valid, prefix, prop, cin, tag_in, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg, tag_out
    );

    modport master (
        output in_valid, prefix, prop, cin, tag_in, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg, tag_out
    );

endinterface

// File: rtl/add_skid_buf.sv
// Two-entry valid/ready buffer; 1 cycle from accept to presentation.
// in_ready depends only on the stored count, so a writeback stall never reaches upstream combinationally.
module add_skid_buf
    import add_pkg::*;
#(
    parameter type T = result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    cnt_e count_q, count_d;
    logic head_q, head_d;
    logic tail_q, tail_d;
    T     mem_q [2];
    logic push;
    logic pop;

    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != EMPTY);
    assign out_data_o  = mem_q[head_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= EMPTY;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (push) begin
                mem_q[tail_q] <= in_data_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            tail_d = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        unique case (count_q)
            EMPTY: if (push) count_d = ONE;
            ONE: begin
                if (push && !pop) begin
                    count_d = FULL;
                end else if (pop && !push) begin
                    count_d = EMPTY;
                end
            end
            FULL:  if (pop) count_d = ONE;
            default: count_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/add_sum_stage.sv
// Final prefix-adder stage: forms sum, carry-out and flags, then registers them in a 2-entry skid buffer.
// Latency 1 cycle; in_ready drops only once both entries are held while writeback stalls.
module add_sum_stage
    import add_pkg::*;
(
    input logic            clk,
    input logic            rst,
    add_sum_stage_if.slave bus
);

    logic [WIDTH:0] carry;
    logic [WIDTH-1:0] sum_w;
    result_t res_in;
    result_t res_out;

    // Prefix pairs exclude carry-in, so it is folded in here through the group propagate
    assign carry[0] = bus.cin;
    for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
        assign carry[i] = bus.prefix[2*(i-1)+G_BIT]
                        | (bus.prefix[2*(i-1)+P_BIT] & bus.cin);
    end

    assign sum_w = bus.prop ^ carry[WIDTH-1:0];

    always_comb begin
        res_in      = '0;
        res_in.sum  = sum_w;
        res_in.cout = carry[WIDTH];
        res_in.ovf  = carry[WIDTH] ^ carry[WIDTH-1];
        res_in.zero = ~|sum_w;
        res_in.neg  = sum_w[WIDTH-1];
        res_in.tag  = bus.tag_in;
    end

    add_skid_buf #(
        .T (result_t)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (res_in),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (res_out)
    );

    assign bus.sum     = res_out.sum;
    assign bus.cout    = res_out.cout;
    assign bus.ovf     = res_out.ovf;
    assign bus.zero    = res_out.zero;
    assign bus.neg     = res_out.neg;
    assign bus.tag_out = res_out.tag;

endmodule
